// File: rtl/seg7_if.sv
// Display-side bundle of the 8-digit scan controller: staged content inputs,
// load/ack handshake and the active-low anode/segment drive lines.
interface seg7_if;
  logic [31:0] DATA;
  logic [7:0]  DP_EN;
  logic [7:0]  DIG_EN;
  logic        LOAD;
  logic        UPD_ACK;
  logic        CA, CB, CC, CD, CE, CF, CG;
  logic        DP;
  logic [7:0]  AN;

  modport master (
    output DATA, DP_EN, DIG_EN, LOAD,
    input  UPD_ACK, CA, CB, CC, CD, CE, CF, CG, DP, AN
  );

  modport slave (
    input  DATA, DP_EN, DIG_EN, LOAD,
    output UPD_ACK, CA, CB, CC, CD, CE, CF, CG, DP, AN
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Contents are double-buffered and swapped only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input logic   clk,
  input logic   rst,
  seg7_if.slave disp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] SLOT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp_en;
    logic [7:0]  dig_en;
  } disp_t;

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic          slot_tick;
  logic          frame_tick;
  logic          in_gap;
  logic          commit;

  disp_t staging;
  disp_t shadow;
  logic  pending;

  logic [7:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;     // {a,b,c,d,e,f,g}, active low
  logic       dp_d, dp_q;
  logic       ack_q;
  logic [3:0] nibble;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign slot_tick  = (prescaler == SLOT_LAST);
  assign frame_tick = slot_tick && (idx == 3'd7);
  assign commit     = frame_tick && pending;

  // A zero-length gap would otherwise be an always-false compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (prescaler < BLANK_END);
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (slot_tick) begin
      prescaler <= '0;
      idx       <= idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The LOAD branch comes last so a same-cycle strobe keeps pending set while
  // the older staging value is the one committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= commit;
      if (commit) begin
        shadow  <= staging;
        pending <= 1'b0;
      end
      if (disp.LOAD) begin
        staging <= '{data: disp.DATA, dp_en: disp.DP_EN, dig_en: disp.DIG_EN};
        pending <= 1'b1;
      end
    end
  end

  assign nibble = shadow.data[{idx, 2'b00} +: 4];

  // NOTE: every output of this block gets a default first, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!in_gap && shadow.dig_en[idx]) begin
      an_d  = ~(8'b1 << idx);
      seg_d = ~decode(nibble);
      dp_d  = ~shadow.dp_en[idx];
    end
  end

  // Anodes and segments share one register stage, so digits never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp.AN      = an_q;
  assign disp.CA      = seg_q[6];
  assign disp.CB      = seg_q[5];
  assign disp.CC      = seg_q[4];
  assign disp.CD      = seg_q[3];
  assign disp.CE      = seg_q[2];
  assign disp.CF      = seg_q[1];
  assign disp.CG      = seg_q[0];
  assign disp.DP      = dp_q;
  assign disp.UPD_ACK = ack_q;

endmodule
